// File: rtl/rgb_pwm_sequencer.sv
// RGB LED colour sequencer: 8-colour table, step/fade/hold/off modes, per-channel PWM
// scaled by a global brightness, driving the board LED through an SB_RGBA_DRV.
module rgb_pwm_sequencer #(
  parameter int    PWM_BITS    = 8,
  parameter int    TICK_CYCLES = 46875,
  parameter string LED_CURRENT = "0b000001"
) (
  input  logic                hw_clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                step_req,
  output logic                led_red,
  output logic                led_green,
  output logic                led_blue,
  output logic [2:0]          color_idx,
  output logic                pwm_sync
);

  localparam int N  = PWM_BITS;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [N-1:0]  LVL_MAX   = '1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  localparam logic [1:0] MODE_STEP = 2'b00;
  localparam logic [1:0] MODE_FADE = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Channel-ordered colour: bit0 = red, bit1 = green, bit2 = blue
  function automatic logic [2:0] colour_bgr(input logic [2:0] idx);
    case (idx)
      3'd0:    colour_bgr = 3'b001;
      3'd1:    colour_bgr = 3'b010;
      3'd2:    colour_bgr = 3'b100;
      3'd3:    colour_bgr = 3'b110;
      3'd4:    colour_bgr = 3'b011;
      3'd5:    colour_bgr = 3'b101;
      3'd6:    colour_bgr = 3'b000;
      default: colour_bgr = 3'b111;
    endcase
  endfunction

  logic [N-1:0]  level_reg [3];
  logic [2:0]    color_idx_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [N-1:0]  dwell_cnt_reg;
  logic [N-1:0]  pwm_cnt_reg;
  logic          pwm_sync_reg;
  logic [1:0]    mode_prev_reg;
  logic [2:0]    pwm_reg;

  logic       running;
  logic       tick;
  logic [2:0] idx_next;
  logic [2:0] rgb_cur;
  logic [2:0] rgb_nxt;
  logic [2:0] at_tgt;
  logic [2:0] pwm_on;
  logic [N:0] bright_p1;

  assign running   = (mode == MODE_STEP) || (mode == MODE_FADE);
  assign tick      = running && (tick_cnt_reg == TICK_LAST);
  assign idx_next  = color_idx_reg + 3'd1;
  assign rgb_cur   = colour_bgr(color_idx_reg);
  assign rgb_nxt   = colour_bgr(idx_next);
  assign bright_p1 = {1'b0, brightness} + (N+1)'(1);

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [N-1:0] tgt;
    logic [2*N:0] prod;
    assign tgt         = rgb_nxt[gi] ? LVL_MAX : '0;
    assign at_tgt[gi]  = (level_reg[gi] == tgt);
    // Full-width product and compare: duty never exceeds 2^N-1, so no clamp is needed
    assign prod        = {{(N+1){1'b0}}, level_reg[gi]} * {{N{1'b0}}, bright_p1};
    assign pwm_on[gi]  = ({{(N+1){1'b0}}, pwm_cnt_reg} < (prod >> N));
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg[0]  <= LVL_MAX;
      level_reg[1]  <= '0;
      level_reg[2]  <= '0;
      color_idx_reg <= '0;
      tick_cnt_reg  <= '0;
      dwell_cnt_reg <= '0;
      pwm_cnt_reg   <= '0;
      pwm_sync_reg  <= 1'b0;
      mode_prev_reg <= MODE_STEP;
      pwm_reg       <= '0;
    end else begin
      pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
      pwm_sync_reg  <= (pwm_cnt_reg == LVL_MAX);
      mode_prev_reg <= mode;
      pwm_reg       <= (mode == MODE_OFF) ? 3'b000 : pwm_on;

      if (running)
        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;

      case (mode)
        MODE_STEP: begin
          // Leaving fade: discard partial levels and restart the dwell
          if (mode_prev_reg == MODE_FADE) begin
            dwell_cnt_reg <= '0;
            for (int c = 0; c < 3; c++)
              level_reg[c] <= rgb_cur[c] ? LVL_MAX : '0;
          end else if (tick) begin
            dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
            if (dwell_cnt_reg == LVL_MAX) begin
              color_idx_reg <= idx_next;
              for (int c = 0; c < 3; c++)
                level_reg[c] <= rgb_nxt[c] ? LVL_MAX : '0;
            end
          end
        end
        MODE_FADE: begin
          if (tick) begin
            if (&at_tgt) begin
              color_idx_reg <= idx_next;
            end else begin
              for (int c = 0; c < 3; c++) begin
                if (rgb_nxt[c] && level_reg[c] != LVL_MAX)
                  level_reg[c] <= level_reg[c] + 1'b1;
                else if (!rgb_nxt[c] && level_reg[c] != '0)
                  level_reg[c] <= level_reg[c] - 1'b1;
              end
            end
          end
        end
        MODE_HOLD: begin
          if (step_req) begin
            color_idx_reg <= idx_next;
            for (int c = 0; c < 3; c++)
              level_reg[c] <= rgb_nxt[c] ? LVL_MAX : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign color_idx = color_idx_reg;
  assign pwm_sync  = pwm_sync_reg;

  SB_RGBA_DRV #(
    .RGB0_CURRENT(LED_CURRENT),
    .RGB1_CURRENT(LED_CURRENT),
    .RGB2_CURRENT(LED_CURRENT)
  ) u_rgb_drv (
    .CURREN   (1'b1),
    .RGBLEDEN (1'b1),
    .RGB0PWM  (pwm_reg[1]),
    .RGB1PWM  (pwm_reg[2]),
    .RGB2PWM  (pwm_reg[0]),
    .RGB0     (led_green),
    .RGB1     (led_blue),
    .RGB2     (led_red)
  );

endmodule

// Behavioural stand-in for the iCE40 RGB current driver: a pad follows its PWM input
// while the driver is enabled and the channel has a non-zero current setting.
module SB_RGBA_DRV #(
  parameter string RGB0_CURRENT = "0b000000",
  parameter string RGB1_CURRENT = "0b000000",
  parameter string RGB2_CURRENT = "0b000000"
) (
  input  logic CURREN,
  input  logic RGBLEDEN,
  input  logic RGB0PWM,
  input  logic RGB1PWM,
  input  logic RGB2PWM,
  output logic RGB0,
  output logic RGB1,
  output logic RGB2
);

  localparam bit CH0_EN = (RGB0_CURRENT != "0b000000");
  localparam bit CH1_EN = (RGB1_CURRENT != "0b000000");
  localparam bit CH2_EN = (RGB2_CURRENT != "0b000000");

  logic drv_en;
  assign drv_en = CURREN & RGBLEDEN;
  assign RGB0   = drv_en & RGB0PWM & CH0_EN;
  assign RGB1   = drv_en & RGB1PWM & CH1_EN;
  assign RGB2   = drv_en & RGB2PWM & CH2_EN;

endmodule
